spram_arbiter: RTL and testbench
================================

# spram_arbiter

Two-port arbiter and sequencer that shares one single-port synchronous RAM (registered read data, write-through `q`, one-cycle read latency) between two requesters, e.g. the Z80 bus (port 0) and the EOS/disk DMA engine (port 1). It serialises requests, drives the RAM address, data and write-enable pins, captures read data, and returns it with a one-cycle acknowledge pulse. It sits between the requesters and the RAM instance.

## Interface
Parameters:
- `AW`, default 16: RAM address width, matched to the RAM `widthad_a`.
- `DW`, default 8: data width, matched to the RAM `width_a`.
- `ROUND_ROBIN`, default 1: 1 selects round-robin arbitration; 0 selects fixed priority, with port 0 always winning.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `p0_req`  in  1  port 0 request level; held with its fields until `p0_ack`.
- `p0_we`  in  1  1 = write, 0 = read.
- `p0_addr`  in  AW  address.
- `p0_wdata`  in  DW  write data.
- `p0_ack`  out  1  one-cycle completion pulse.
- `p0_rdata`  out  DW  read data; valid while `p0_ack` is high and held afterwards.
- `p1_req`, `p1_we`, `p1_addr`, `p1_wdata`, `p1_ack`, `p1_rdata`: identical signals for port 1.
- `ram_addr`  out  AW  to RAM `address`.
- `ram_data`  out  DW  to RAM `data`.
- `ram_wren`  out  1  to RAM `wren`.
- `ram_q`  in  DW  from RAM `q`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, ACK.
- **IDLE:** if any req is high, pick a winner, register `ram_addr`, `ram_data` and `ram_wren` (= winner `we`) from the winner's fields, store the grant index, then go to ISSUE. Otherwise stay in IDLE.
- **ISSUE:** `ram_wren` is high only in this state, and only for writes. The RAM performs the access at the closing edge. `ram_wren` is cleared at that edge. Go to WAIT.
- **WAIT:** `ram_q` is valid. At the closing edge, latch `ram_q` into the granted port's rdata, set that port's ack, and update `last_grant`. Go to ACK.
- **ACK:** the granted port's ack is high for exactly this cycle. At the closing edge, ack clears.
  - If the other port's req is high, grant it directly (ACK→ISSUE, registering its fields).
  - Otherwise go to IDLE.
  - The just-acked port is never re-granted from ACK. Its req is still high in this cycle and is ignored.
- **Round-robin:** on a tie, the port not equal to `last_grant` wins. `last_grant` resets to 1, so port 0 wins the first tie.
- **Fixed priority:** on a tie, port 0 always wins.
- **Writes:** ack pulses as for reads. rdata returns the written data, because the RAM is write-through.
- Non-granted rdata registers hold their previous value.
- The address wraps naturally within AW. No range checking.
- Requesters must not change fields while req is high and ack has not yet been seen. Behaviour otherwise is undefined.

## Timing
- Req sampled high at edge E0 (FSM in IDLE). State after each edge:
  - after E0: ISSUE;
  - after E1: WAIT;
  - after E2: ACK, with ack high and rdata valid;
  - after E3: IDLE or ISSUE.
- Latency from req sampled to ack high: 2 cycles. An isolated access occupies 4 cycles.
- Back-to-back accesses alternating between ports: one grant every 3 cycles.
- The same port cannot complete accesses faster than every 4 cycles. It must drop req for at least the cycle after ack.
- Reset values: `p0_ack`=0, `p1_ack`=0, `p0_rdata`=0, `p1_rdata`=0, `ram_addr`=0, `ram_data`=0, `ram_wren`=0, `busy`=0, state=IDLE, `last_grant`=1.
- Reset mid-access: the FSM returns to IDLE at that edge and no ack is issued. `ram_wren` is low from that edge on. A write whose ISSUE edge coincides with the reset edge is not guaranteed to occur.

## Test plan
- **Single read:** preload RAM[0x1234]=0xA5; assert `p0_req`, `p0_we`=0, addr 0x1234 → `p0_ack` is high 2 cycles after req is sampled, with `p0_rdata`=0xA5. Port 1 outputs stay unchanged.
- **Write then read:** port 1 writes 0x3C to 0x0010 → `ram_wren` is high for exactly 1 cycle and `p1_rdata`=0x3C at ack. Port 0 then reads 0x0010 → 0x3C.
- **Tie from reset, round-robin:** both ports request in the same cycle → port 0 is acked first. Port 1 is granted directly from ACK and acked 3 cycles after port 0's ack.
- **Continuous contention:** both ports re-request immediately after each ack for 20 accesses → grants strictly alternate, 10 per port. With `ROUND_ROBIN`=0, port 0 wins every tie.
- **Reset during WAIT of a read:** no ack is produced, all outputs return to their reset values, and a following request completes normally.
- **Reset during ISSUE of a write, then idle:** `ram_wren` is 0 from the reset edge onward and `busy`=0.

Source files
------------

// File: rtl/spram_arbiter.sv
// Shares one single-port synchronous RAM between two requesters (port 0, port 1).
// Latency: request sampled in IDLE -> ack high two cycles later; isolated access takes 4 cycles.
// Backpressure: requesters hold req and fields until their one-cycle ack; the loser simply waits.
module spram_arbiter #(
    parameter int AW          = 16,
    parameter int DW          = 8,
    parameter int ROUND_ROBIN = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic [DW-1:0] p1_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          ram_wren,
    input  logic [DW-1:0] ram_q,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t        state;
    logic          grant;       // port currently being served
    logic          last_grant;  // port most recently acked, used for round-robin ties
    logic          pick;        // winner when arbitrating from IDLE
    logic          load_sel;    // port whose fields get registered into the RAM pins
    logic          other_req;   // the non-granted port is requesting (used in ACK)
    logic          load_we;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_wdata;

    // Winner selection from IDLE and field mux for whichever port is about to be issued.
    always_comb begin
        pick = 1'b0;
        if (p0_req && p1_req) begin
            pick = (ROUND_ROBIN != 0) ? ~last_grant : 1'b0;
        end else if (p1_req) begin
            pick = 1'b1;
        end
        // From ACK only the other port may be granted; the just-acked port's req is ignored.
        other_req  = grant ? p0_req : p1_req;
        load_sel   = (state == ACK) ? ~grant : pick;
        load_we    = load_sel ? p1_we    : p0_we;
        load_addr  = load_sel ? p1_addr  : p0_addr;
        load_wdata = load_sel ? p1_wdata : p0_wdata;
    end

    // Sequencer: IDLE -> ISSUE -> WAIT -> ACK, with a direct ACK -> ISSUE hand-over.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            ram_addr   <= '0;
            ram_data   <= '0;
            ram_wren   <= 1'b0;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        grant    <= load_sel;
                        ram_addr <= load_addr;
                        ram_data <= load_wdata;
                        ram_wren <= load_we;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The RAM performs the access at this edge; write enable is one cycle wide.
                    ram_wren <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // Write-through RAM: q carries the written data for writes too.
                    if (grant) begin
                        p1_rdata <= ram_q;
                        p1_ack   <= 1'b1;
                    end else begin
                        p0_rdata <= ram_q;
                        p0_ack   <= 1'b1;
                    end
                    last_grant <= grant;
                    state      <= ACK;
                end
                ACK: begin
                    p0_ack <= 1'b0;
                    p1_ack <= 1'b0;
                    if (other_req) begin
                        grant    <= load_sel;
                        ram_addr <= load_addr;
                        ram_data <= load_wdata;
                        ram_wren <= load_we;
                        state    <= ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter: round-robin instance plus a fixed-priority instance
// driven by the same requests, each with its own behavioural write-through RAM.
module tb_spram_arbiter;

    logic        clock;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [15:0] p0_addr, p1_addr;
    logic [7:0]  p0_wdata, p1_wdata;

    logic        p0_ack, p1_ack, ram_wren, busy;
    logic [7:0]  p0_rdata, p1_rdata, ram_data, ram_q;
    logic [15:0] ram_addr;

    logic        f_p0_ack, f_p1_ack, f_ram_wren, f_busy;
    logic [7:0]  f_p0_rdata, f_p1_rdata, f_ram_data, f_ram_q;
    logic [15:0] f_ram_addr;

    int vectors;
    int miscompares;

    logic [7:0] mem_a [0:65535];
    logic [7:0] mem_b [0:65535];

    spram_arbiter #(.AW(16), .DW(8), .ROUND_ROBIN(1)) dut (
        .clock(clock), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
        .busy(busy)
    );

    spram_arbiter #(.AW(16), .DW(8), .ROUND_ROBIN(0)) dut_fp (
        .clock(clock), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(f_p0_ack), .p0_rdata(f_p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(f_p1_ack), .p1_rdata(f_p1_rdata),
        .ram_addr(f_ram_addr), .ram_data(f_ram_data), .ram_wren(f_ram_wren), .ram_q(f_ram_q),
        .busy(f_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single-port RAM models: registered q, write-through on write.
    always @(posedge clock) begin
        if (ram_wren) begin
            mem_a[ram_addr] = ram_data;
            ram_q <= ram_data;
        end else begin
            ram_q <= mem_a[ram_addr];
        end
    end

    always @(posedge clock) begin
        if (f_ram_wren) begin
            mem_b[f_ram_addr] = f_ram_data;
            f_ram_q <= f_ram_data;
        end else begin
            f_ram_q <= mem_b[f_ram_addr];
        end
    end

    task automatic do_reset();
        reset  = 1'b1;
        p0_req = 1'b0;
        p1_req = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Drives one access on a port and waits (bounded) for its ack; lat counts negedges
    // after the request was raised, so ack two cycles after the sampling edge gives lat == 3.
    task automatic access(input int port, input logic we, input logic [15:0] addr,
                          input logic [7:0] wd, output int lat, output logic [7:0] rd,
                          output int wren_cyc, output int other_ack);
        lat = -1; rd = 8'h00; wren_cyc = 0; other_ack = 0;
        if (port == 0) begin
            p0_we = we; p0_addr = addr; p0_wdata = wd; p0_req = 1'b1;
        end else begin
            p1_we = we; p1_addr = addr; p1_wdata = wd; p1_req = 1'b1;
        end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (ram_wren) wren_cyc++;
            if ((port == 0) ? p1_ack : p0_ack) other_ack++;
            if ((port == 0) ? p0_ack : p1_ack) begin
                lat = c;
                rd  = (port == 0) ? p0_rdata : p1_rdata;
                break;
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        p0_we = 0; p1_we = 0; p0_addr = 0; p1_addr = 0; p0_wdata = 0; p1_wdata = 0;
        reset  = 1'b1;
        p0_req = 1'b0;
        p1_req = 1'b0;
        repeat (2) @(negedge clock);
        vectors++; if (p0_ack !== 1'b0) begin miscompares++; $display("FAIL reset_p0_ack got %0h want 0", p0_ack); end
        vectors++; if (p1_ack !== 1'b0) begin miscompares++; $display("FAIL reset_p1_ack got %0h want 0", p1_ack); end
        vectors++; if (p0_rdata !== 8'h00) begin miscompares++; $display("FAIL reset_p0_rdata got %0h want 0", p0_rdata); end
        vectors++; if (p1_rdata !== 8'h00) begin miscompares++; $display("FAIL reset_p1_rdata got %0h want 0", p1_rdata); end
        vectors++; if (ram_addr !== 16'h0000) begin miscompares++; $display("FAIL reset_ram_addr got %0h want 0", ram_addr); end
        vectors++; if (ram_data !== 8'h00) begin miscompares++; $display("FAIL reset_ram_data got %0h want 0", ram_data); end
        vectors++; if (ram_wren !== 1'b0) begin miscompares++; $display("FAIL reset_ram_wren got %0h want 0", ram_wren); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0h want 0", busy); end
        vectors++;
        if ({f_p0_ack, f_p1_ack, f_p0_rdata, f_p1_rdata, f_busy} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_fp_outputs got %0h want 0", {f_p0_ack, f_p1_ack, f_p0_rdata, f_p1_rdata, f_busy});
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_single_read();
        int lat, wc, oa;
        logic [7:0] rd;
        access(0, 1'b0, 16'h1234, 8'h00, lat, rd, wc, oa);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL read_latency got %0d want 3", lat); end
        vectors++; if (rd !== 8'hA5) begin miscompares++; $display("FAIL read_p0_rdata got %0h want a5", rd); end
        vectors++; if (oa !== 0) begin miscompares++; $display("FAIL read_p1_ack_pulses got %0d want 0", oa); end
        vectors++; if (p1_rdata !== 8'h00) begin miscompares++; $display("FAIL read_p1_rdata_held got %0h want 0", p1_rdata); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL read_busy_after got %0h want 0", busy); end
    endtask

    task automatic test_write_then_read();
        int lat, wc, oa;
        logic [7:0] rd;
        access(1, 1'b1, 16'h0010, 8'h3C, lat, rd, wc, oa);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL write_latency got %0d want 3", lat); end
        vectors++; if (wc !== 1) begin miscompares++; $display("FAIL write_wren_cycles got %0d want 1", wc); end
        vectors++; if (rd !== 8'h3C) begin miscompares++; $display("FAIL write_p1_rdata got %0h want 3c", rd); end
        vectors++; if (mem_a[16'h0010] !== 8'h3C) begin miscompares++; $display("FAIL write_ram_content got %0h want 3c", mem_a[16'h0010]); end
        vectors++; if (p0_rdata !== 8'hA5) begin miscompares++; $display("FAIL write_p0_rdata_held got %0h want a5", p0_rdata); end
        access(0, 1'b0, 16'h0010, 8'h00, lat, rd, wc, oa);
        vectors++; if (wc !== 0) begin miscompares++; $display("FAIL readback_wren_cycles got %0d want 0", wc); end
        vectors++; if (rd !== 8'h3C) begin miscompares++; $display("FAIL readback_p0_rdata got %0h want 3c", rd); end
    endtask

    task automatic test_tie();
        int a0, a1;
        logic [7:0] r0, r1;
        do_reset();
        a0 = -1; a1 = -1; r0 = 8'h00; r1 = 8'h00;
        p0_we = 1'b0; p0_addr = 16'h1234; p1_we = 1'b0; p1_addr = 16'h0010;
        p0_req = 1'b1; p1_req = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (p0_ack) begin a0 = c; r0 = p0_rdata; p0_req = 1'b0; end
            if (p1_ack) begin a1 = c; r1 = p1_rdata; p1_req = 1'b0; break; end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        @(negedge clock);
        vectors++; if (a0 !== 3) begin miscompares++; $display("FAIL tie_p0_ack_cycle got %0d want 3", a0); end
        vectors++; if (a1 !== 6) begin miscompares++; $display("FAIL tie_p1_ack_cycle got %0d want 6", a1); end
        vectors++; if (r0 !== 8'hA5) begin miscompares++; $display("FAIL tie_p0_rdata got %0h want a5", r0); end
        vectors++; if (r1 !== 8'h3C) begin miscompares++; $display("FAIL tie_p1_rdata got %0h want 3c", r1); end
    endtask

    // After a port-0 access, a tie goes to port 1 under round-robin but to port 0 under fixed priority.
    task automatic test_fixed_priority();
        int lat, wc, oa;
        logic [7:0] rd;
        do_reset();
        access(0, 1'b0, 16'h1234, 8'h00, lat, rd, wc, oa);
        p0_we = 1'b0; p0_addr = 16'h1234; p1_we = 1'b0; p1_addr = 16'h0010;
        p0_req = 1'b1; p1_req = 1'b1;
        repeat (3) @(negedge clock);
        vectors++; if ({p0_ack, p1_ack} !== 2'b01) begin miscompares++; $display("FAIL rr_second_tie acks got %b want 01", {p0_ack, p1_ack}); end
        vectors++; if (p1_rdata !== 8'h3C) begin miscompares++; $display("FAIL rr_second_tie_rdata got %0h want 3c", p1_rdata); end
        vectors++; if ({f_p0_ack, f_p1_ack} !== 2'b10) begin miscompares++; $display("FAIL fp_second_tie acks got %b want 10", {f_p0_ack, f_p1_ack}); end
        vectors++; if (f_p0_rdata !== 8'hA5) begin miscompares++; $display("FAIL fp_second_tie_rdata got %0h want a5", f_p0_rdata); end
        p0_req = 1'b0; p1_req = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_contention();
        int n, n0, n1, prev, last_c, port;
        logic d0, d1;
        do_reset();
        n = 0; n0 = 0; n1 = 0; prev = -1; last_c = 0; d0 = 1'b0; d1 = 1'b0;
        p0_we = 1'b0; p0_addr = 16'h1234; p1_we = 1'b0; p1_addr = 16'h0010;
        p0_req = 1'b1; p1_req = 1'b1;
        for (int c = 1; c <= 200 && n < 20; c++) begin
            @(negedge clock);
            if (d0) begin p0_req = 1'b1; d0 = 1'b0; end
            if (d1) begin p1_req = 1'b1; d1 = 1'b0; end
            if (p0_ack || p1_ack) begin
                port = p1_ack ? 1 : 0;
                n++;
                if (port == 1) n1++; else n0++;
                if (n == 1) begin
                    vectors++;
                    if (port != 0 || c != 3) begin miscompares++; $display("FAIL contention_first got port %0d cycle %0d want port 0 cycle 3", port, c); end
                end else begin
                    vectors++;
                    if (port == prev) begin miscompares++; $display("FAIL contention_alternate ack %0d got port %0d want port %0d", n, port, 1 - prev); end
                    vectors++;
                    if (c - last_c != 3) begin miscompares++; $display("FAIL contention_gap ack %0d got %0d cycles want 3", n, c - last_c); end
                end
                vectors++;
                if ((port == 0 ? p0_rdata : p1_rdata) !== (port == 0 ? 8'hA5 : 8'h3C)) begin
                    miscompares++;
                    $display("FAIL contention_rdata ack %0d got %0h want %0h", n, (port == 0 ? p0_rdata : p1_rdata), (port == 0 ? 8'hA5 : 8'h3C));
                end
                prev = port; last_c = c;
                if (port == 0) begin p0_req = 1'b0; d0 = 1'b1; end
                else begin p1_req = 1'b0; d1 = 1'b1; end
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        repeat (2) @(negedge clock);
        vectors++; if (n0 !== 10) begin miscompares++; $display("FAIL contention_p0_count got %0d want 10", n0); end
        vectors++; if (n1 !== 10) begin miscompares++; $display("FAIL contention_p1_count got %0d want 10", n1); end
    endtask

    task automatic test_reset_wait();
        int lat, wc, oa, stray;
        logic [7:0] rd;
        stray = 0;
        p0_we = 1'b0; p0_addr = 16'h1234; p0_req = 1'b1;
        repeat (2) @(negedge clock);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rstwait_busy_before got %0h want 1", busy); end
        reset = 1'b1; p0_req = 1'b0;
        @(negedge clock);
        vectors++; if (p0_ack !== 1'b0) begin miscompares++; $display("FAIL rstwait_p0_ack got %0h want 0", p0_ack); end
        vectors++; if ({p0_rdata, p1_rdata} !== 16'h0000) begin miscompares++; $display("FAIL rstwait_rdata got %0h want 0", {p0_rdata, p1_rdata}); end
        vectors++; if ({ram_addr, ram_data, ram_wren, busy} !== 26'd0) begin miscompares++; $display("FAIL rstwait_ram_busy got %0h want 0", {ram_addr, ram_data, ram_wren, busy}); end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (p0_ack || p1_ack) stray++;
        end
        vectors++; if (stray !== 0) begin miscompares++; $display("FAIL rstwait_stray_ack got %0d want 0", stray); end
        access(0, 1'b0, 16'h1234, 8'h00, lat, rd, wc, oa);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL rstwait_next_latency got %0d want 3", lat); end
        vectors++; if (rd !== 8'hA5) begin miscompares++; $display("FAIL rstwait_next_rdata got %0h want a5", rd); end
    endtask

    task automatic test_reset_issue_write();
        int bad;
        bad = 0;
        p1_we = 1'b1; p1_addr = 16'h0020; p1_wdata = 8'h55; p1_req = 1'b1;
        @(negedge clock);
        vectors++; if ({ram_wren, ram_data} !== 9'h155) begin miscompares++; $display("FAIL rstissue_issue got %0h want 155", {ram_wren, ram_data}); end
        reset = 1'b1; p1_req = 1'b0;
        @(negedge clock);
        vectors++; if ({ram_wren, busy} !== 2'b00) begin miscompares++; $display("FAIL rstissue_at_reset got %b want 00", {ram_wren, busy}); end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (ram_wren || busy) bad++;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL rstissue_idle_after got %0d bad cycles want 0", bad); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        mem_a[16'h1234] = 8'hA5;
        mem_b[16'h1234] = 8'hA5;
        reset = 1'b1; p0_req = 1'b0; p1_req = 1'b0;
        test_reset();
        test_single_read();
        test_write_then_read();
        test_tie();
        test_fixed_priority();
        test_contention();
        test_reset_wait();
        test_reset_issue_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
